spm_dump_reader: RTL and testbench

- Test-port reader: the other side of the loader flow that writes instructions into the SPM test port.
- After a `start`, it issues back-to-back word reads over the SPM test port (test_spm_as_/rw/addr, test_spm_rd_data) from a base address for a given word count.
- Each word goes out as a valid/ready stream tagged with its address. A running checksum is kept.
- Used by benches and the debug path to dump/verify SPM contents after `cpu_en` is released.

---
 rtl/spm_dump_reader_pkg.sv | 36 +++
 rtl/spm_dump_fifo2.sv | 73 +++++++
 rtl/spm_dump_reader.sv | 135 +++++++++++++
 tb/tb_spm_dump_reader.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/spm_dump_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spm_dump_reader_pkg
// Description : Shared constants for the SPM dump reader: test-port bus
//               widths, the READ encoding of the rw strobe, the dump FSM
//               state encodings and the read-credit helper.
// Revision    : 1.0 - initial release
// ============================================================================
package spm_dump_reader_pkg;

    // Test-port geometry (word-addressed bus width and word width).
    localparam int c_WORD_ADDR_W = 30;
    localparam int c_WORD_W      = 32;

    // rw encoding on the SPM test port.
    localparam logic c_READ = 1'b1;

    // Dump FSM state encodings.
    localparam logic [1:0] c_DUMP_IDLE  = 2'd0;
    localparam logic [1:0] c_DUMP_ISSUE = 2'd1;
    localparam logic [1:0] c_DUMP_DRAIN = 2'd2;

    // A new read may be strobed only if, after this cycle's pop, the FIFO
    // entries plus the read still in flight leave room for one more word.
    // Counting the same-cycle pop keeps the pipe full at one word per cycle
    // while never letting the two-entry FIFO overflow.
    function automatic logic f_credit_ok(input logic [1:0] fifo_count,
                                         input logic       inflight,
                                         input logic       pop);
        logic [2:0] used;
        used = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
        return (used < 3'd2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spm_dump_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : spm_dump_fifo2
// Description : Two-entry synchronous FIFO. Entry 0 is always the head, so
//               the head is a plain register and stays stable until popped.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               i_push/i_push_data - write strobe and word
//               i_pop            - remove head (ignored when empty)
//               o_head           - head entry
//               o_count          - occupancy 0..2
//               o_full/o_empty   - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module spm_dump_fifo2 #(
    parameter int WIDTH = 62
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [1:0]       o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [WIDTH-1:0] r_e0;
    logic [WIDTH-1:0] r_e1;
    logic [1:0]       r_count;
    logic             w_pop;
    logic             w_push;

    assign o_empty = (r_count == 2'd0);
    assign o_full  = (r_count == 2'd2);
    assign w_pop   = i_pop && !o_empty;
    assign w_push  = i_push && (!o_full || w_pop);
    assign o_head  = r_e0;
    assign o_count = r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e0    <= '0;
            r_e1    <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_e0 <= i_push_data;
                    else                 r_e1 <= i_push_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_e0    <= r_e1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind whatever
                    // remains after the head leaves.
                    if (r_count == 2'd1) begin
                        r_e0 <= i_push_data;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= i_push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spm_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : spm_dump_reader
// Description : Reads word_cnt words from the SPM test port starting at
//               base_addr and streams them out as (addr, data) on a
//               valid/ready interface, keeping a running checksum.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               start/base_addr/word_cnt - dump request (sampled in idle)
//               test_spm_as_/rw/addr/rd_data - SPM test port (read only)
//               dump_valid/ready/data/addr   - output word stream
//               busy, done, checksum - status
// Revision    : 1.0 - initial release
// ============================================================================
module spm_dump_reader
    import spm_dump_reader_pkg::*;
#(
    parameter int ADDR_W      = c_WORD_ADDR_W,
    parameter int DATA_W      = c_WORD_W,
    parameter int CNT_W       = 16,
    parameter int ADDR_STRIDE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    output logic              test_spm_as_,
    output logic              test_spm_rw,
    output logic [ADDR_W-1:0] test_spm_addr,
    input  logic [DATA_W-1:0] test_spm_rd_data,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    localparam logic [ADDR_W-1:0] c_STRIDE = ADDR_W'(ADDR_STRIDE);

    logic [1:0]               r_state;
    logic [ADDR_W-1:0]        r_cur_addr;
    logic [ADDR_W-1:0]        r_inflight_addr;
    logic [CNT_W-1:0]         r_issue_left;
    logic                     r_inflight;
    logic                     r_done;
    logic [DATA_W-1:0]        r_checksum;

    logic [ADDR_W+DATA_W-1:0] w_head;
    logic [1:0]               w_fifo_count;
    logic                     w_fifo_full;
    logic                     w_fifo_empty;
    logic                     w_pop;
    logic                     w_issue;
    logic                     w_final;

    assign w_pop   = !w_fifo_empty && dump_ready;
    assign w_issue = (r_state == c_DUMP_ISSUE) && !(w_fifo_full && !w_pop)
                     && f_credit_ok(w_fifo_count, r_inflight, w_pop);
    // Last word leaving: nothing else buffered and nothing on its way back.
    assign w_final = (r_state == c_DUMP_DRAIN) && w_pop
                     && (w_fifo_count == 2'd1) && !r_inflight;

    assign test_spm_as_  = !w_issue;
    assign test_spm_rw   = c_READ;
    assign test_spm_addr = r_cur_addr;
    assign dump_valid    = !w_fifo_empty;
    assign dump_data     = w_head[DATA_W-1:0];
    assign dump_addr     = w_head[ADDR_W+DATA_W-1:DATA_W];
    assign busy          = (r_state != c_DUMP_IDLE);
    assign done          = r_done;
    assign checksum      = r_checksum;

    // Read data returns one cycle after the strobe; it is pushed together
    // with the address that was strobed.
    spm_dump_fifo2 #(
        .WIDTH (ADDR_W + DATA_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (r_inflight),
        .i_push_data ({r_inflight_addr, test_spm_rd_data}),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_fifo_count),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= c_DUMP_IDLE;
            r_cur_addr      <= '0;
            r_inflight_addr <= '0;
            r_issue_left    <= '0;
            r_inflight      <= 1'b0;
            r_done          <= 1'b0;
            r_checksum      <= '0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_addr <= r_cur_addr;
            r_done          <= w_final;
            if (w_pop) r_checksum <= r_checksum + w_head[DATA_W-1:0];

            case (r_state)
                c_DUMP_IDLE: begin
                    if (start) begin
                        r_checksum <= '0;
                        if (word_cnt == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_cur_addr   <= base_addr;
                            r_issue_left <= word_cnt;
                            r_state      <= c_DUMP_ISSUE;
                        end
                    end
                end
                c_DUMP_ISSUE: begin
                    if (w_issue) begin
                        r_cur_addr   <= r_cur_addr + c_STRIDE;
                        r_issue_left <= r_issue_left - 1'b1;
                        if (r_issue_left == CNT_W'(1)) r_state <= c_DUMP_DRAIN;
                    end
                end
                c_DUMP_DRAIN: begin
                    if (w_final) r_state <= c_DUMP_IDLE;
                end
                default: r_state <= c_DUMP_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spm_dump_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_dump_reader
// Description : Directed self-checking bench for spm_dump_reader with a
//               one-cycle-latency SPM read model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [29:0] base_addr;
    logic [15:0] word_cnt;
    logic        test_spm_as_;
    logic        test_spm_rw;
    logic [29:0] test_spm_addr;
    logic [31:0] test_spm_rd_data;
    logic        dump_valid;
    logic        dump_ready;
    logic [31:0] dump_data;
    logic [29:0] dump_addr;
    logic        busy;
    logic        done;
    logic [31:0] checksum;

    always #5 clk = ~clk;

    spm_dump_reader dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .base_addr        (base_addr),
        .word_cnt         (word_cnt),
        .test_spm_as_     (test_spm_as_),
        .test_spm_rw      (test_spm_rw),
        .test_spm_addr    (test_spm_addr),
        .test_spm_rd_data (test_spm_rd_data),
        .dump_valid       (dump_valid),
        .dump_ready       (dump_ready),
        .dump_data        (dump_data),
        .dump_addr        (dump_addr),
        .busy             (busy),
        .done             (done),
        .checksum         (checksum)
    );

    // SPM model: data for a strobed read appears the following cycle.
    logic [31:0] mem [0:15];
    always @(posedge clk) begin
        if (!test_spm_as_ && test_spm_rw) test_spm_rd_data <= mem[test_spm_addr[5:2]];
    end

    int checks = 0;
    int errors = 0;

    // Per-dump observations gathered by run_collect.
    int          n_acc, first_valid, last_acc, done_cyc, n_done, busy_cyc;
    int          n_strobes, stab_err, credit_err, rw_err;
    bit          timed_out;
    logic [29:0] acc_addr [0:15];
    logic [31:0] acc_data [0:15];
    logic [7:0]  ready_pat;
    logic [31:0] exp_data [0:3];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Launches a dump and records what comes out; cycle 0 is the cycle in
    // which start is presented, the strobes start in cycle 1.
    task automatic run_collect(input logic [29:0] base, input logic [15:0] cnt,
                               input bit toggle, input int restart_c);
        int          issued, accepted;
        logic        prev_stall, rdy;
        logic [29:0] prev_addr;
        logic [31:0] prev_data;
        issued = 0; accepted = 0; prev_stall = 1'b0; prev_addr = '0; prev_data = '0;
        n_acc = 0; first_valid = -1; last_acc = -1; done_cyc = -1; n_done = 0;
        busy_cyc = 0; stab_err = 0; credit_err = 0; rw_err = 0;
        cyc();
        start = 1'b1; base_addr = base; word_cnt = cnt;
        dump_ready = toggle ? ready_pat[0] : 1'b1;
        for (int c = 1; c <= 200; c++) begin
            cyc();
            start = (c == restart_c);
            if (c == restart_c) begin base_addr = 30'd12; word_cnt = 16'd1; end
            rdy = toggle ? ready_pat[c % 8] : 1'b1;
            dump_ready = rdy;
            #3;
            if (test_spm_rw !== 1'b1) rw_err++;
            if (busy === 1'b1) busy_cyc++;
            if (test_spm_as_ === 1'b0) begin
                if ((issued - accepted - ((dump_valid && rdy) ? 1 : 0)) >= 2) credit_err++;
                issued++;
            end
            if (dump_valid && prev_stall && (dump_data !== prev_data || dump_addr !== prev_addr))
                stab_err++;
            if (dump_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (dump_valid === 1'b1 && rdy) begin
                if (n_acc < 16) begin acc_addr[n_acc] = dump_addr; acc_data[n_acc] = dump_data; end
                n_acc++; accepted++; last_acc = c;
            end
            prev_stall = dump_valid && !rdy; prev_data = dump_data; prev_addr = dump_addr;
            if (done === 1'b1) begin n_done++; if (done_cyc < 0) done_cyc = c; end
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        n_strobes = issued;
        timed_out = (done_cyc < 0);
        start = 1'b0; dump_ready = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; base_addr = '0; word_cnt = '0; dump_ready = 1'b1;
        cyc(); cyc(); #3;
        checks++; if (test_spm_as_ !== 1'b1) begin errors++; $display("FAIL rst_as got %b exp 1", test_spm_as_); end
        checks++; if (test_spm_rw !== 1'b1) begin errors++; $display("FAIL rst_rw got %b exp 1", test_spm_rw); end
        checks++; if (test_spm_addr !== 30'd0) begin errors++; $display("FAIL rst_addr got %h exp 0", test_spm_addr); end
        checks++; if (dump_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL rst_flags got v%b b%b d%b exp 000", dump_valid, busy, done); end
        checks++; if (dump_data !== 32'd0 || dump_addr !== 30'd0 || checksum !== 32'd0)
            begin errors++; $display("FAIL rst_regs got %h %h %h exp 0", dump_data, dump_addr, checksum); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        run_collect(30'd0, 16'd4, 1'b0, -1);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
        checks++; if (n_acc !== 4) begin errors++; $display("FAIL basic_count got %0d exp 4", n_acc); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (acc_addr[i] !== 30'(i * 4) || acc_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL basic_word%0d got %h/%h exp %h/%h", i, acc_addr[i], acc_data[i], i * 4, exp_data[i]);
            end
        end
        checks++; if (first_valid !== 3 || last_acc !== 6)
            begin errors++; $display("FAIL basic_valid_window got %0d..%0d exp 3..6", first_valid, last_acc); end
        checks++; if (done_cyc !== 7 || n_done !== 1)
            begin errors++; $display("FAIL basic_done got cyc%0d n%0d exp cyc7 n1", done_cyc, n_done); end
        checks++; if (busy_cyc !== 6) begin errors++; $display("FAIL basic_busy got %0d exp 6", busy_cyc); end
        checks++; if (n_strobes !== 4 || rw_err !== 0)
            begin errors++; $display("FAIL basic_strobes got %0d rw_err %0d exp 4 0", n_strobes, rw_err); end
        checks++; if (checksum !== 32'h0060_034C) begin errors++; $display("FAIL basic_checksum got %h exp 0060034c", checksum); end
    endtask

    task automatic test_backpressure();
        run_collect(30'd0, 16'd4, 1'b1, -1);
        checks++; if (timed_out || n_acc !== 4 || n_done !== 1)
            begin errors++; $display("FAIL bp_count got acc%0d done%0d to%0b exp 4 1 0", n_acc, n_done, timed_out); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (acc_addr[i] !== 30'(i * 4) || acc_data[i] !== exp_data[i]) begin
                errors++; $display("FAIL bp_word%0d got %h/%h exp %h/%h", i, acc_addr[i], acc_data[i], i * 4, exp_data[i]);
            end
        end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable got %0d exp 0", stab_err); end
        checks++; if (credit_err !== 0 || n_strobes !== 4)
            begin errors++; $display("FAIL bp_credit got err%0d strobes%0d exp 0 4", credit_err, n_strobes); end
        checks++; if (checksum !== 32'h0060_034C) begin errors++; $display("FAIL bp_checksum got %h exp 0060034c", checksum); end
    endtask

    task automatic test_zero_count();
        run_collect(30'd0, 16'd0, 1'b0, -1);
        checks++; if (n_strobes !== 0 || busy_cyc !== 0)
            begin errors++; $display("FAIL zero_idle got strobes%0d busy%0d exp 0 0", n_strobes, busy_cyc); end
        checks++; if (done_cyc !== 1 || n_done !== 1)
            begin errors++; $display("FAIL zero_done got cyc%0d n%0d exp cyc1 n1", done_cyc, n_done); end
        checks++; if (checksum !== 32'd0) begin errors++; $display("FAIL zero_checksum got %h exp 0", checksum); end
    endtask

    task automatic test_wrap();
        run_collect(30'h3FFF_FFFC, 16'd2, 1'b0, -1);
        checks++; if (n_acc !== 2) begin errors++; $display("FAIL wrap_count got %0d exp 2", n_acc); end
        checks++; if (acc_addr[0] !== 30'h3FFF_FFFC || acc_data[0] !== 32'hDEAD_BEEF)
            begin errors++; $display("FAIL wrap_word0 got %h/%h exp 3ffffffc/deadbeef", acc_addr[0], acc_data[0]); end
        checks++; if (acc_addr[1] !== 30'd0 || acc_data[1] !== 32'h0000_0013)
            begin errors++; $display("FAIL wrap_word1 got %h/%h exp 0/00000013", acc_addr[1], acc_data[1]); end
    endtask

    task automatic test_reset_mid();
        cyc(); start = 1'b1; base_addr = 30'd0; word_cnt = 16'd4; dump_ready = 1'b1;
        cyc(); start = 1'b0; #3;
        checks++; if (test_spm_as_ !== 1'b0) begin errors++; $display("FAIL mid_strobe got %b exp 0", test_spm_as_); end
        cyc(); reset = 1'b1;
        cyc(); reset = 1'b0; #3;
        checks++; if (test_spm_as_ !== 1'b1 || busy !== 1'b0 || dump_valid !== 1'b0 || done !== 1'b0)
            begin errors++; $display("FAIL mid_flags got as%b b%b v%b d%b exp 1000", test_spm_as_, busy, dump_valid, done); end
        checks++; if (test_spm_addr !== 30'd0 || dump_data !== 32'd0 || dump_addr !== 30'd0 || checksum !== 32'd0)
            begin errors++; $display("FAIL mid_regs got %h %h %h %h exp 0", test_spm_addr, dump_data, dump_addr, checksum); end
        cyc(); #3;
        checks++; if (dump_valid !== 1'b0) begin errors++; $display("FAIL mid_discard got %b exp 0", dump_valid); end
        run_collect(30'd8, 16'd1, 1'b0, -1);
        checks++; if (n_acc !== 1 || acc_addr[0] !== 30'd8 || acc_data[0] !== 32'h0020_0113)
            begin errors++; $display("FAIL mid_after got n%0d %h/%h exp 1 8/00200113", n_acc, acc_addr[0], acc_data[0]); end
        checks++; if (checksum !== 32'h0020_0113) begin errors++; $display("FAIL mid_checksum got %h exp 00200113", checksum); end
    endtask

    task automatic test_restart_ignored();
        run_collect(30'd0, 16'd4, 1'b0, 2);
        checks++; if (n_acc !== 4 || n_strobes !== 4 || n_done !== 1)
            begin errors++; $display("FAIL restart_count got acc%0d str%0d done%0d exp 4 4 1", n_acc, n_strobes, n_done); end
        checks++; if (acc_addr[3] !== 30'd12 || acc_data[3] !== exp_data[3])
            begin errors++; $display("FAIL restart_last got %h/%h exp c/%h", acc_addr[3], acc_data[3], exp_data[3]); end
        checks++; if (checksum !== 32'h0060_034C) begin errors++; $display("FAIL restart_checksum got %h exp 0060034c", checksum); end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        mem[0]  = 32'h0000_0013;
        mem[1]  = 32'h0010_0093;
        mem[2]  = 32'h0020_0113;
        mem[3]  = 32'h0030_0193;
        mem[15] = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) exp_data[i] = mem[i];
        ready_pat = 8'h69;   // 1,0,0,1,0,1,1,0 from bit 0 upward
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_count();
        test_wrap();
        test_reset_mid();
        test_restart_ignored();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
